// File: rtl/sobel_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sobel_pkg
// Purpose  : Shared types, output-mode codes and edge saturation for the
//            Sobel frame sequencer.
// Revision : 1.0
// ============================================================================
package sobel_pkg;

  localparam int SOBEL_DATA_W = 12;
  localparam int SOBEL_EDGE_W = 15;

  localparam logic [1:0] MODE_GRAY = 2'd0;
  localparam logic [1:0] MODE_EDGE = 2'd1;
  localparam logic [1:0] MODE_THR  = 2'd2;

  typedef enum logic [1:0] {IDLE, PRIME, ACTIVE, DONE} sobel_state_t;

  // Clamp the unsaturated |Gx|+|Gy| sum to the pixel range.
  function automatic logic [SOBEL_DATA_W-1:0] sat_edge(input logic [SOBEL_EDGE_W-1:0] edgeVal);
    if (|edgeVal[SOBEL_EDGE_W-1:SOBEL_DATA_W])
      return '1;
    else
      return edgeVal[SOBEL_DATA_W-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/sobel_pos_counter.sv
`default_nettype none
// ============================================================================
// Module   : sobel_pos_counter
// Purpose  : Column/row position of the current pixel with row-end and
//            last-pixel flags.
// Revision : 1.0
// ============================================================================
module sobel_pos_counter #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic       iClear,
  input  logic       iInc,
  output logic [9:0] oX,
  output logic [8:0] oY,
  output logic       oRowEnd,
  output logic       oLastPixel
);

  localparam logic [9:0] C_X_LAST = 10'(IMG_W - 1);
  localparam logic [8:0] C_Y_LAST = 9'(IMG_H - 1);

  assign oRowEnd    = (oX == C_X_LAST);
  assign oLastPixel = oRowEnd && (oY == C_Y_LAST);

  // Row index saturates on the final pixel so it never leaves the frame.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      oX <= '0;
      oY <= '0;
    end else if (iClear) begin
      oX <= '0;
      oY <= '0;
    end else if (iInc) begin
      if (oRowEnd) begin
        oX <= '0;
        if (oY != C_Y_LAST)
          oY <= oY + 9'd1;
      end else begin
        oX <= oX + 10'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/sobel_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sobel_frame_ctrl
// Purpose  : Frame sequencer for the Sobel pipeline: position tracking,
//            line-buffer enable, window masking and output-mode selection.
// Revision : 1.0
// ============================================================================
module sobel_frame_ctrl
  import sobel_pkg::*;
#(
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480,
  parameter int DATA_W = SOBEL_DATA_W,
  parameter int EDGE_W = SOBEL_EDGE_W
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iFVAL,
  input  logic              iDVAL,
  input  logic [DATA_W-1:0] iGray,
  input  logic [EDGE_W-1:0] iEdge,
  input  logic [1:0]        iMode,
  input  logic [DATA_W-1:0] iThresh,
  output logic              oLbEn,
  output logic              oDVAL,
  output logic [DATA_W-1:0] oPixel,
  output logic [9:0]        oX,
  output logic [8:0]        oY,
  output logic              oFrameDone,
  output logic              oFrameErr
);

  sobel_state_t      r_state;
  sobel_state_t      w_stateNext;
  logic              r_fvalQ;
  logic [1:0]        r_mode;
  logic [DATA_W-1:0] r_thresh;
  logic              w_fvalRise;
  logic              w_accept;
  logic              w_frameStart;
  logic              w_err;
  logic [9:0]        w_x;
  logic [8:0]        w_y;
  logic              w_rowEnd;
  logic              w_lastPixel;
  logic [DATA_W-1:0] w_sat;
  logic [DATA_W-1:0] w_modePix;
  logic [DATA_W-1:0] w_pixNext;

  assign w_fvalRise = iFVAL & ~r_fvalQ;
  assign w_accept   = iDVAL & iFVAL & ((r_state == PRIME) || (r_state == ACTIVE));
  assign oLbEn      = w_accept;

  sobel_pos_counter #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H)
  ) u_pos (
    .iCLK       (iCLK),
    .iRST       (iRST),
    .iClear     (w_frameStart),
    .iInc       (w_accept),
    .oX         (w_x),
    .oY         (w_y),
    .oRowEnd    (w_rowEnd),
    .oLastPixel (w_lastPixel)
  );

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST)
      r_state <= IDLE;
    else
      r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext  = r_state;
    w_frameStart = 1'b0;
    w_err        = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_fvalRise) begin
          w_stateNext  = PRIME;
          w_frameStart = 1'b1;
        end
      end
      PRIME: begin
        if (!iFVAL) begin
          w_stateNext = IDLE;
          w_err       = 1'b1;
        end else if (w_accept && w_rowEnd && (w_y == 9'd1)) begin
          w_stateNext = ACTIVE;
        end
      end
      ACTIVE: begin
        if (!iFVAL) begin
          w_stateNext = IDLE;
          w_err       = 1'b1;
        end else if (w_accept && w_lastPixel) begin
          w_stateNext = DONE;
        end
      end
      DONE:    w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  always_comb begin
    w_sat = sat_edge(iEdge);
    case (r_mode)
      MODE_GRAY: w_modePix = iGray;
      MODE_THR:  w_modePix = (w_sat >= r_thresh) ? '1 : '0;
      MODE_EDGE: w_modePix = w_sat;
      default:   w_modePix = w_sat;
    endcase
    w_pixNext = ((w_x < 10'd2) || (w_y < 9'd2)) ? '0 : w_modePix;
  end

  // r_fvalQ resets high so a frame already running at reset release is
  // not mistaken for a new frame start.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_fvalQ    <= 1'b1;
      r_mode     <= MODE_EDGE;
      r_thresh   <= '0;
      oDVAL      <= 1'b0;
      oPixel     <= '0;
      oX         <= '0;
      oY         <= '0;
      oFrameDone <= 1'b0;
      oFrameErr  <= 1'b0;
    end else begin
      r_fvalQ    <= iFVAL;
      oDVAL      <= w_accept;
      oFrameDone <= (r_state == DONE);
      oFrameErr  <= w_err;
      if (w_frameStart) begin
        r_mode   <= iMode;
        r_thresh <= iThresh;
      end
      if (w_accept) begin
        oPixel <= w_pixNext;
        oX     <= w_x;
        oY     <= w_y;
      end
    end
  end

endmodule
`default_nettype wire
